// File: rtl/select_ctrl_param.sv
// Flood-It setup/selection controller: debounced button setup, board-init and
// begin-game handshakes, switch-driven colour selection and tries budgeting.
module select_ctrl_param #(
  parameter int MAX_COLORS      = 8,
  parameter int COLOR_MIN       = 3,
  parameter int SIZE_MIN        = 2,
  parameter int SIZE_MAX        = 26,
  parameter int SIZE_STEP       = 4,
  parameter int SIZE_DEF        = 14,
  parameter int COLOR_DEF       = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TRY_W           = 8
) (
  input  logic                          MASTER_CLOCK,
  input  logic                          RESET,
  input  logic                          UP,
  input  logic                          DOWN,
  input  logic                          LEFT,
  input  logic                          RIGHT,
  input  logic                          CENTER,
  input  logic [MAX_COLORS-1:0]         sw,
  input  logic                          BOARD_READY,
  input  logic                          INITIALIZED,
  input  logic                          ACK_BEGIN_GAME,
  input  logic                          CURRENTLY_CHANGING_COLOR,
  input  logic                          GAME_WON,
  output logic                          INITIALIZE_BOARD,
  output logic                          BEGIN_GAME,
  output logic                          COLOR_SEL_SIG,
  output logic [$clog2(MAX_COLORS)-1:0] COLOR_SELECTED,
  output logic [4:0]                    SIZE,
  output logic [4:0]                    final_SIZE,
  output logic [3:0]                    COLOR_NUM,
  output logic [3:0]                    final_COLOR_NUM,
  output logic                          sORc,
  output logic                          MODE,
  output logic [TRY_W-1:0]              TRIES,
  output logic [TRY_W-1:0]              TOTAL_TRIES,
  output logic                          GAME_OVER,
  output logic                          GAME_LOST
);

  localparam int CSW   = $clog2(MAX_COLORS);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] SZ_MIN  = 5'(SIZE_MIN);
  localparam logic [4:0] SZ_MAX  = 5'(SIZE_MAX);
  localparam logic [4:0] SZ_STEP = 5'(SIZE_STEP);
  localparam logic [4:0] SZ_DEF  = 5'(SIZE_DEF);
  localparam logic [3:0] CN_MIN  = 4'(COLOR_MIN);
  localparam logic [3:0] CN_MAX  = 4'(MAX_COLORS);
  localparam logic [3:0] CN_DEF  = 4'(COLOR_DEF);

  typedef enum logic [2:0] {
    S_BOOT, S_SETUP, S_INIT, S_BEGIN, S_PLAY, S_SEL, S_WAITC, S_OVER
  } state_t;

  function automatic logic [TRY_W-1:0] budget(input logic [4:0] s, input logic [3:0] c);
    logic [15:0] p;
    p = 16'(s) * 16'(c) * 16'd19;
    return TRY_W'(p >> 6);
  endfunction

  // Button conditioning: index 0..4 = UP, DOWN, LEFT, RIGHT, CENTER.
  logic [4:0]       btn_raw, btn_s1_q, btn_s2_q, lvl_q, lvl_prev_q, press_q;
  logic [CNT_W-1:0] db_cnt_q [5];

  assign btn_raw = {CENTER, RIGHT, LEFT, DOWN, UP};

  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
      for (int unsigned i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      lvl_prev_q <= lvl_q;
      press_q    <= lvl_q & ~lvl_prev_q;
      for (int unsigned i = 0; i < 5; i++) begin
        if (btn_s2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          lvl_q[i]    <= btn_s2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic btn_up, btn_dn, btn_lt, btn_rt, btn_ct;
  assign {btn_ct, btn_rt, btn_lt, btn_dn, btn_up} = press_q;

  // Switch toggle detection; sw_prev follows the synchronised switches every cycle.
  logic [MAX_COLORS-1:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic                  tog_hit;
  logic [CSW-1:0]        tog_idx;

  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
    end
  end

  logic [3:0] fcn_q;

  always_comb begin
    tog_hit = 1'b0;
    tog_idx = '0;
    for (int unsigned i = 0; i < MAX_COLORS; i++) begin
      if (!tog_hit && (sw_s2_q[i] != sw_prev_q[i]) && (i < 32'(fcn_q))) begin
        tog_hit = 1'b1;
        tog_idx = CSW'(i);
      end
    end
  end

  state_t           state_q, state_d;
  logic [4:0]       size_q, size_d, fsize_q, fsize_d;
  logic [3:0]       cn_q, cn_d, fcn_d;
  logic             sorc_q, sorc_d, mode_q, mode_d, over_q, over_d, lost_q, lost_d;
  logic [TRY_W-1:0] tries_q, tries_d, total_q, total_d;
  logic [CSW-1:0]   csel_q, csel_d;

  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_BOOT;
      size_q  <= SZ_DEF;
      fsize_q <= SZ_DEF;
      cn_q    <= CN_DEF;
      fcn_q   <= CN_DEF;
      sorc_q  <= 1'b0;
      mode_q  <= 1'b1;
      tries_q <= '0;
      total_q <= budget(SZ_DEF, CN_DEF);
      over_q  <= 1'b0;
      lost_q  <= 1'b0;
      csel_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      fsize_q <= fsize_d;
      cn_q    <= cn_d;
      fcn_q   <= fcn_d;
      sorc_q  <= sorc_d;
      mode_q  <= mode_d;
      tries_q <= tries_d;
      total_q <= total_d;
      over_q  <= over_d;
      lost_q  <= lost_d;
      csel_q  <= csel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    fsize_d = fsize_q;
    cn_d    = cn_q;
    fcn_d   = fcn_q;
    sorc_d  = sorc_q;
    mode_d  = mode_q;
    tries_d = tries_q;
    total_d = total_q;
    over_d  = over_q;
    lost_d  = lost_q;
    csel_d  = csel_q;
    unique case (state_q)
      S_BOOT: state_d = INITIALIZED ? S_PLAY : S_INIT;
      S_SETUP: begin
        if (btn_up) begin
          if (sorc_q) size_d = (size_q >= SZ_MAX) ? SZ_MIN : size_q + SZ_STEP;
          else        cn_d   = (cn_q >= CN_MAX)   ? CN_MIN : cn_q + 4'd1;
        end else if (btn_dn) begin
          if (sorc_q) size_d = (size_q <= SZ_MIN) ? SZ_MAX : size_q - SZ_STEP;
          else        cn_d   = (cn_q <= CN_MIN)   ? CN_MAX : cn_q - 4'd1;
        end
        if (btn_lt) sorc_d = ~sorc_q;
        // CENTER latches the pre-edit setup values when pressed together with UP/DOWN.
        if (btn_rt) begin
          if (INITIALIZED) begin
            state_d = S_PLAY;
            mode_d  = 1'b1;
          end
        end else if (btn_ct) begin
          fsize_d = size_q;
          fcn_d   = cn_q;
          total_d = budget(size_q, cn_q);
          state_d = S_INIT;
        end
      end
      S_INIT:  if (BOARD_READY) state_d = S_BEGIN;
      S_BEGIN: begin
        if (ACK_BEGIN_GAME) begin
          tries_d = '0;
          over_d  = 1'b0;
          lost_d  = 1'b0;
          mode_d  = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tog_hit) begin
          csel_d  = tog_idx;
          if (tries_q != '1) tries_d = tries_q + 1'b1;
          state_d = S_SEL;
        end else if (btn_rt) begin
          mode_d  = 1'b0;
          state_d = S_SETUP;
        end else if (btn_ct) begin
          state_d = S_INIT;
        end
      end
      S_SEL: if (CURRENTLY_CHANGING_COLOR) state_d = S_WAITC;
      S_WAITC: begin
        if (!CURRENTLY_CHANGING_COLOR) begin
          if (GAME_WON) begin
            over_d  = 1'b1;
            lost_d  = 1'b0;
            state_d = S_OVER;
          end else if (tries_q >= total_q) begin
            over_d  = 1'b1;
            lost_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_PLAY;
          end
        end
      end
      S_OVER: begin
        if (btn_rt) begin
          mode_d  = 1'b0;
          state_d = S_SETUP;
        end else if (btn_ct) begin
          state_d = S_INIT;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign INITIALIZE_BOARD = (state_q == S_INIT);
  assign BEGIN_GAME       = (state_q == S_BEGIN);
  assign COLOR_SEL_SIG    = (state_q == S_SEL);
  assign COLOR_SELECTED   = csel_q;
  assign SIZE             = size_q;
  assign final_SIZE       = fsize_q;
  assign COLOR_NUM        = cn_q;
  assign final_COLOR_NUM  = fcn_q;
  assign sORc             = sorc_q;
  assign MODE             = mode_q;
  assign TRIES            = tries_q;
  assign TOTAL_TRIES      = total_q;
  assign GAME_OVER        = over_q;
  assign GAME_LOST        = lost_q;

endmodule

// File: tb/tb_select_ctrl_param.sv
// Directed bench for select_ctrl_param with a short debounce window.
module tb_select_ctrl_param;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;  // UP, DOWN, LEFT, RIGHT, CENTER
  logic [7:0] sw_v = '0;
  logic       board_ready = 1'b0, initialized = 1'b0, ack = 1'b0, ccc = 1'b0, won = 1'b0;
  logic       init_board, begin_game, csel_sig, sorc, mode, over, lost;
  logic [2:0] csel;
  logic [4:0] size, fsize;
  logic [3:0] cnum, fcnum;
  logic [7:0] tries, total;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  select_ctrl_param #(.DEBOUNCE_CYCLES(D)) dut (
    .MASTER_CLOCK(clk), .RESET(rst),
    .UP(btn[0]), .DOWN(btn[1]), .LEFT(btn[2]), .RIGHT(btn[3]), .CENTER(btn[4]),
    .sw(sw_v), .BOARD_READY(board_ready), .INITIALIZED(initialized),
    .ACK_BEGIN_GAME(ack), .CURRENTLY_CHANGING_COLOR(ccc), .GAME_WON(won),
    .INITIALIZE_BOARD(init_board), .BEGIN_GAME(begin_game), .COLOR_SEL_SIG(csel_sig),
    .COLOR_SELECTED(csel), .SIZE(size), .final_SIZE(fsize), .COLOR_NUM(cnum),
    .final_COLOR_NUM(fcnum), .sORc(sorc), .MODE(mode), .TRIES(tries),
    .TOTAL_TRIES(total), .GAME_OVER(over), .GAME_LOST(lost)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(D + 8);
    btn[b] = 1'b0;
    cyc(D + 8);
  endtask

  task automatic handshake();
    board_ready = 1'b1; cyc(1); board_ready = 1'b0; cyc(1);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
  endtask

  task automatic colour_move(input logic [7:0] mask);
    sw_v = sw_v ^ mask;
    cyc(5);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    checks++; if (init_board !== 1'b0 || begin_game !== 1'b0 || csel_sig !== 1'b0) begin
      $display("FAIL reset_req got=%b%b%b exp=000", init_board, begin_game, csel_sig); failures++; end
    checks++; if (size !== 5'd14 || fsize !== 5'd14 || cnum !== 4'd6 || fcnum !== 4'd6) begin
      $display("FAIL reset_setup got=%0d/%0d/%0d/%0d exp=14/14/6/6", size, fsize, cnum, fcnum); failures++; end
    checks++; if (total !== 8'd24 || tries !== 8'd0 || mode !== 1'b1 || sorc !== 1'b0 || over !== 1'b0 || lost !== 1'b0) begin
      $display("FAIL reset_play got=total%0d tries%0d mode%b sorc%b over%b lost%b exp=24 0 1 0 0 0", total, tries, mode, sorc, over, lost); failures++; end
    cyc(1); rst = 1'b0;
    cyc(2);
    checks++; if (init_board !== 1'b1) begin
      $display("FAIL boot_init got=%b exp=1", init_board); failures++; end
    board_ready = 1'b1; cyc(1); board_ready = 1'b0;
    checks++; if (init_board !== 1'b0 || begin_game !== 1'b1) begin
      $display("FAIL init_done got=%b%b exp=01", init_board, begin_game); failures++; end
    cyc(3);
    checks++; if (begin_game !== 1'b1) begin
      $display("FAIL begin_hold got=%b exp=1", begin_game); failures++; end
    ack = 1'b1; cyc(1); ack = 1'b0;
    checks++; if (begin_game !== 1'b0 || mode !== 1'b1) begin
      $display("FAIL begin_ack got=bg%b mode%b exp=bg0 mode1", begin_game, mode); failures++; end
    initialized = 1'b1;
  endtask

  task automatic test_setup();
    logic [3:0] exp_c [4];
    exp_c[0] = 4'd7; exp_c[1] = 4'd8; exp_c[2] = 4'd3; exp_c[3] = 4'd4;
    press(3);
    checks++; if (mode !== 1'b0) begin
      $display("FAIL setup_mode got=%b exp=0", mode); failures++; end
    for (int i = 0; i < 4; i++) begin
      press(0);
      checks++; if (cnum !== exp_c[i]) begin
        $display("FAIL color_up%0d got=%0d exp=%0d", i, cnum, exp_c[i]); failures++; end
    end
    for (int k = 0; k < 2; k++) begin
      btn[0] = 1'b1; cyc(D - 1); btn[0] = 1'b0; cyc(1);
    end
    cyc(D + 8);
    checks++; if (cnum !== 4'd4) begin
      $display("FAIL bounce got=%0d exp=4", cnum); failures++; end
    press(2);
    checks++; if (sorc !== 1'b1) begin
      $display("FAIL left got=%b exp=1", sorc); failures++; end
    press(1);
    checks++; if (size !== 5'd10 || cnum !== 4'd4) begin
      $display("FAIL size_down got=%0d/%0d exp=10/4", size, cnum); failures++; end
    press(4);
    checks++; if (fsize !== 5'd10 || fcnum !== 4'd4 || total !== 8'd11 || init_board !== 1'b1) begin
      $display("FAIL center got=%0d/%0d/%0d/%b exp=10/4/11/1", fsize, fcnum, total, init_board); failures++; end
    handshake();
  endtask

  task automatic test_play();
    colour_move(8'b0010_0100);
    checks++; if (csel_sig !== 1'b1 || csel !== 3'd2 || tries !== 8'd1) begin
      $display("FAIL sel_low got=sig%b idx%0d tries%0d exp=sig1 idx2 tries1", csel_sig, csel, tries); failures++; end
    ccc = 1'b1; #1;
    checks++; if (csel_sig !== 1'b1) begin
      $display("FAIL sel_hold got=%b exp=1", csel_sig); failures++; end
    cyc(1);
    checks++; if (csel_sig !== 1'b0) begin
      $display("FAIL sel_drop got=%b exp=0", csel_sig); failures++; end
    ccc = 1'b0; cyc(2);
    checks++; if (over !== 1'b0 || mode !== 1'b1) begin
      $display("FAIL back_play got=over%b mode%b exp=over0 mode1", over, mode); failures++; end
    colour_move(8'b0000_1010);
    checks++; if (csel_sig !== 1'b1 || csel !== 3'd1 || tries !== 8'd2) begin
      $display("FAIL sel_prio got=sig%b idx%0d tries%0d exp=sig1 idx1 tries2", csel_sig, csel, tries); failures++; end
    ccc = 1'b1; cyc(1); ccc = 1'b0; cyc(2);
    colour_move(8'b0010_0000);
    cyc(2);
    checks++; if (csel_sig !== 1'b0 || tries !== 8'd2) begin
      $display("FAIL sel_range got=sig%b tries%0d exp=sig0 tries2", csel_sig, tries); failures++; end
  endtask

  task automatic test_lose();
    press(3);
    press(1); press(1);
    press(2);
    press(1);
    checks++; if (size !== 5'd2 || cnum !== 4'd3 || sorc !== 1'b0) begin
      $display("FAIL lose_setup got=%0d/%0d/%b exp=2/3/0", size, cnum, sorc); failures++; end
    press(4);
    checks++; if (fsize !== 5'd2 || fcnum !== 4'd3 || total !== 8'd1) begin
      $display("FAIL lose_latch got=%0d/%0d/%0d exp=2/3/1", fsize, fcnum, total); failures++; end
    handshake();
    checks++; if (tries !== 8'd0) begin
      $display("FAIL tries_clear got=%0d exp=0", tries); failures++; end
    colour_move(8'b0001_0000);
    cyc(2);
    checks++; if (csel_sig !== 1'b0 || tries !== 8'd0) begin
      $display("FAIL sw4_ignored got=sig%b tries%0d exp=sig0 tries0", csel_sig, tries); failures++; end
    colour_move(8'b0000_0001);
    checks++; if (csel_sig !== 1'b1 || csel !== 3'd0 || tries !== 8'd1) begin
      $display("FAIL lose_move got=sig%b idx%0d tries%0d exp=sig1 idx0 tries1", csel_sig, csel, tries); failures++; end
    ccc = 1'b1; cyc(1); ccc = 1'b0; cyc(2);
    checks++; if (over !== 1'b1 || lost !== 1'b1) begin
      $display("FAIL lost got=over%b lost%b exp=over1 lost1", over, lost); failures++; end
    colour_move(8'b0000_0010);
    cyc(2);
    checks++; if (csel_sig !== 1'b0 || tries !== 8'd1) begin
      $display("FAIL over_ignore got=sig%b tries%0d exp=sig0 tries1", csel_sig, tries); failures++; end
  endtask

  task automatic test_wrap();
    press(3);
    press(2);
    press(1);
    checks++; if (size !== 5'd26) begin
      $display("FAIL size_wrap_down got=%0d exp=26", size); failures++; end
    press(0);
    checks++; if (size !== 5'd2) begin
      $display("FAIL size_wrap_up got=%0d exp=2", size); failures++; end
    press(2);
    press(1);
    checks++; if (cnum !== 4'd8) begin
      $display("FAIL color_wrap_down got=%0d exp=8", cnum); failures++; end
    press(4);
    checks++; if (fsize !== 5'd2 || fcnum !== 4'd8 || total !== 8'd4) begin
      $display("FAIL wrap_latch got=%0d/%0d/%0d exp=2/8/4", fsize, fcnum, total); failures++; end
    handshake();
    checks++; if (over !== 1'b0 || lost !== 1'b0 || tries !== 8'd0) begin
      $display("FAIL restart_clear got=over%b lost%b tries%0d exp=0 0 0", over, lost, tries); failures++; end
  endtask

  task automatic test_win();
    colour_move(8'b1000_0000);
    checks++; if (csel_sig !== 1'b1 || csel !== 3'd7 || tries !== 8'd1) begin
      $display("FAIL win_move got=sig%b idx%0d tries%0d exp=sig1 idx7 tries1", csel_sig, csel, tries); failures++; end
    won = 1'b1; ccc = 1'b1; cyc(1); ccc = 1'b0; cyc(2); won = 1'b0;
    checks++; if (over !== 1'b1 || lost !== 1'b0) begin
      $display("FAIL won got=over%b lost%b exp=over1 lost0", over, lost); failures++; end
    press(4);
    checks++; if (init_board !== 1'b1) begin
      $display("FAIL over_center got=%b exp=1", init_board); failures++; end
    handshake();
  endtask

  task automatic test_reset_in_sel();
    colour_move(8'b0000_1000);
    checks++; if (csel_sig !== 1'b1 || tries !== 8'd1) begin
      $display("FAIL pre_reset got=sig%b tries%0d exp=sig1 tries1", csel_sig, tries); failures++; end
    initialized = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (csel_sig !== 1'b0 || tries !== 8'd0 || fsize !== 5'd14) begin
      $display("FAIL async_reset got=sig%b tries%0d fsize%0d exp=sig0 tries0 fsize14", csel_sig, tries, fsize); failures++; end
    cyc(1); rst = 1'b0;
    cyc(2);
    checks++; if (init_board !== 1'b1 || csel_sig !== 1'b0) begin
      $display("FAIL reboot got=init%b sig%b exp=init1 sig0", init_board, csel_sig); failures++; end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_play();
    test_lose();
    test_wrap();
    test_win();
    test_reset_in_sel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/select_ctrl_param.md
Name: select_ctrl_param

Overview:
Parametrised successor to the Flood-It setup/selection controller. It turns debounced button presses into board-size and colour-count setup, and sequences board initialisation and the begin-game handshake. During play it converts switch toggles into colour-select requests and tracks the tries budget until a win or loss. It sits between the board-IO pins and the rand/game-logic blocks.

Parameters:
MAX_COLORS, 8, number of colour switches; upper bound of COLOR_NUM
COLOR_MIN, 3, lowest selectable colour count
SIZE_MIN, 2, smallest board size
SIZE_MAX, 26, largest board size
SIZE_STEP, 4, size increment; (SIZE_MAX-SIZE_MIN) is a multiple of SIZE_STEP
SIZE_DEF, 14, size after reset
COLOR_DEF, 6, colour count after reset
DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a button level
TRY_W, 8, width of the tries counters

Ports:
MASTER_CLOCK  in  1  system clock, 100 MHz
RESET  in  1  asynchronous, active-high reset
UP, DOWN, LEFT, RIGHT, CENTER  in  1 each  raw push buttons
sw  in  MAX_COLORS  raw colour switches
BOARD_READY  in  1  rand has finished filling the board
INITIALIZED  in  1  game logic holds a valid board
ACK_BEGIN_GAME  in  1  game logic accepted BEGIN_GAME
CURRENTLY_CHANGING_COLOR  in  1  game logic is busy flooding
GAME_WON  in  1  board is a single colour
INITIALIZE_BOARD  out  1  request to rand
BEGIN_GAME  out  1  start request to game logic
COLOR_SEL_SIG  out  1  colour-select request
COLOR_SELECTED  out  clog2(MAX_COLORS)  selected colour index
SIZE, final_SIZE  out  5 each  setup value / latched play value
COLOR_NUM, final_COLOR_NUM  out  4 each  setup value / latched play value
sORc  out  1  0 = UP/DOWN edits COLOR_NUM, 1 = edits SIZE
MODE  out  1  1 = play, 0 = setup
TRIES, TOTAL_TRIES  out  TRY_W each  moves used / budget
GAME_OVER, GAME_LOST  out  1 each  end-of-game flags

Behaviour:
- Reset values: all request outputs 0; SIZE and final_SIZE = SIZE_DEF; COLOR_NUM and final_COLOR_NUM = COLOR_DEF; sORc = 0; MODE = 1; TRIES = 0; TOTAL_TRIES = budget(SIZE_DEF, COLOR_DEF); GAME_OVER = 0; GAME_LOST = 0; FSM = BOOT.
- Buttons: 2-flop synchroniser, then a debounce counter. A level is accepted after DEBOUNCE_CYCLES consecutive equal samples. The rising edge of the accepted level gives a 1-cycle press pulse. Press latency is DEBOUNCE_CYCLES+3 cycles from a clean pin edge.
- Switches: 2-flop synchroniser. sw_prev is updated every cycle in every state. A toggle is sw_s[i] != sw_prev[i]; only indices i < final_COLOR_NUM count. The lowest index wins.
- budget(S,C) = (S*C*19)>>6, computed in at least 14-bit intermediate width, then truncated to TRY_W. Examples: 14,6→24; 26,8→61; 2,3→1.
- FSM states:
  - BOOT: goes to INIT when INITIALIZED = 0, otherwise to PLAY.
  - SETUP (MODE = 0):
    - UP/DOWN steps the field chosen by sORc by ±SIZE_STEP or ±1, with wrap-around: SIZE_MAX+step→SIZE_MIN, SIZE_MIN-step→SIZE_MAX, MAX_COLORS+1→COLOR_MIN, COLOR_MIN-1→MAX_COLORS.
    - LEFT toggles sORc.
    - CENTER latches final_* ← SIZE, COLOR_NUM and TOTAL_TRIES ← budget, then goes to INIT.
    - RIGHT goes to PLAY only if INITIALIZED = 1; final_* are unchanged.
  - INIT: INITIALIZE_BOARD = 1 until BOARD_READY, then BEGIN.
  - BEGIN: BEGIN_GAME = 1 until ACK_BEGIN_GAME. On that cycle clear TRIES, GAME_OVER and GAME_LOST, set MODE = 1, and go to PLAY.
  - PLAY (MODE = 1):
    - A valid toggle sets COLOR_SELECTED, increments TRIES (saturating at all-ones), and goes to SEL.
    - RIGHT goes to SETUP.
    - CENTER goes to INIT (restart with the current final_*).
  - SEL: COLOR_SEL_SIG = 1 until CURRENTLY_CHANGING_COLOR = 1, then WAITC.
  - WAITC: waits for CURRENTLY_CHANGING_COLOR = 0, then:
    - GAME_WON → OVER with GAME_OVER = 1 and GAME_LOST = 0;
    - else TRIES >= TOTAL_TRIES → OVER with GAME_OVER = 1 and GAME_LOST = 1;
    - else PLAY.
  - OVER: switch toggles are ignored; RIGHT → SETUP; CENTER → INIT.
- Simultaneous events in one cycle: switch toggle beats RIGHT, and RIGHT beats CENTER. In SETUP, UP beats DOWN, and LEFT is applied in the same cycle. Presses in INIT, BEGIN, SEL and WAITC are discarded.
- Toggles occurring outside PLAY are absorbed by sw_prev and never replayed.
- RESET mid-handshake drops every request in the same cycle (asynchronous) and restarts from BOOT.

Test Plan:
- Reset with INITIALIZED = 0, BOARD_READY pulsed → INITIALIZE_BOARD high then low; BEGIN_GAME held until ACK_BEGIN_GAME; final_SIZE = 14, final_COLOR_NUM = 6, TOTAL_TRIES = 24, MODE = 1.
- Run with DEBOUNCE_CYCLES = 4. RIGHT, then UP×4 (sORc = 0) → COLOR_NUM 6→7→8→3→4. Then LEFT, then DOWN → SIZE 14→10. CENTER → final = (10, 4), TOTAL_TRIES = 11.
- Bounce UP for fewer than DEBOUNCE_CYCLES → no COLOR_NUM change.
- In PLAY, toggle sw[2] and sw[5] in the same cycle → COLOR_SELECTED = 2 and TRIES = 1. COLOR_SEL_SIG drops the cycle after CURRENTLY_CHANGING_COLOR rises.
- With final_COLOR_NUM = 3, toggle sw[4] → ignored. Make TOTAL_TRIES = 1 valid moves with GAME_WON = 0 → GAME_OVER = 1, GAME_LOST = 1, and further toggles are ignored.
- Assert RESET while in SEL → COLOR_SEL_SIG = 0 immediately, TRIES = 0, FSM = BOOT.
